tia_collision_detector: RTL and testbench

Collision latch and readback block for the TIA: consumes the serial object outputs (`px`/`mx` from the two player graphics instances, plus ball and playfield serial bits) every pixel clock. It latches all 15 pairwise object overlaps, clears them on a CXCLR strobe, and returns them to the CPU read path as the eight TIA collision registers (CXM0P..CXPPMM). It is the read-side counterpart of the player/missile graphics write path.

---
 rtl/tia_collision_detector.sv | 192 +++++++++++++++++++
 tb/tb_tia_collision_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tia_collision_detector.sv
// TIA collision latch and CPU readback.
// Registers the six serial object bits each pixel clock, latches all fifteen
// pairwise overlaps as sticky flags, clears them on cxclr, and serves them
// back as the eight TIA collision registers.
// Optional feature macro: TIA_CX_FIRST_HIT_EN adds a column counter that
// records the column of the first P0-P1 overlap (readable at addr 8/9).

module tia_collision_detector (
   input  logic       clkp,
   input  logic       reset_bar,
   input  logic       p0,
   input  logic       p1,
   input  logic       m0,
   input  logic       m1,
   input  logic       bl,
   input  logic       pf,
   input  logic       blank,
   input  logic       line_start,
   input  logic       cxclr,
   input  logic       rd_req,
   input  logic [3:0] addr,
   output logic       rd_ack,
   output logic [7:0] rd_data
);

   // Collision latch bit positions
   localparam int CX_M0P1 = 0;
   localparam int CX_M0P0 = 1;
   localparam int CX_M1P0 = 2;
   localparam int CX_M1P1 = 3;
   localparam int CX_P0PF = 4;
   localparam int CX_P0BL = 5;
   localparam int CX_P1PF = 6;
   localparam int CX_P1BL = 7;
   localparam int CX_M0PF = 8;
   localparam int CX_M0BL = 9;
   localparam int CX_M1PF = 10;
   localparam int CX_M1BL = 11;
   localparam int CX_BLPF = 12;
   localparam int CX_P0P1 = 13;
   localparam int CX_M0M1 = 14;

   logic        s1_p0;
   logic        s1_p1;
   logic        s1_m0;
   logic        s1_m1;
   logic        s1_bl;
   logic        s1_pf;
   logic [14:0] cx;
   logic [14:0] hits;
   logic [14:0] cx_view;
   logic [7:0]  rd_mux;

   // Stage S1: capture the pixel's object bits, blanked pixels contribute nothing
   always_ff @(posedge clkp) begin
      if (!reset_bar) begin
         s1_p0 <= 1'b0;
         s1_p1 <= 1'b0;
         s1_m0 <= 1'b0;
         s1_m1 <= 1'b0;
         s1_bl <= 1'b0;
         s1_pf <= 1'b0;
      end else begin
         s1_p0 <= p0 & ~blank;
         s1_p1 <= p1 & ~blank;
         s1_m0 <= m0 & ~blank;
         s1_m1 <= m1 & ~blank;
         s1_bl <= bl & ~blank;
         s1_pf <= pf & ~blank;
      end
   end

   // Pairwise overlap detection on the registered pixel
   always_comb begin
      hits          = '0;
      hits[CX_M0P1] = s1_m0 & s1_p1;
      hits[CX_M0P0] = s1_m0 & s1_p0;
      hits[CX_M1P0] = s1_m1 & s1_p0;
      hits[CX_M1P1] = s1_m1 & s1_p1;
      hits[CX_P0PF] = s1_p0 & s1_pf;
      hits[CX_P0BL] = s1_p0 & s1_bl;
      hits[CX_P1PF] = s1_p1 & s1_pf;
      hits[CX_P1BL] = s1_p1 & s1_bl;
      hits[CX_M0PF] = s1_m0 & s1_pf;
      hits[CX_M0BL] = s1_m0 & s1_bl;
      hits[CX_M1PF] = s1_m1 & s1_pf;
      hits[CX_M1BL] = s1_m1 & s1_bl;
      hits[CX_BLPF] = s1_bl & s1_pf;
      hits[CX_P0P1] = s1_p0 & s1_p1;
      hits[CX_M0M1] = s1_m0 & s1_m1;
   end

   // Stage S2: sticky latches; a clear discards any set arriving on the same edge
   always_ff @(posedge clkp) begin
      if (!reset_bar) begin
         cx <= '0;
      end else if (cxclr) begin
         cx <= '0;
      end else begin
         cx <= cx | hits;
      end
   end

   // Reads see the latches as they are about to become, ignoring a concurrent
   // clear, so a pixel is readable one edge after it reaches S1 and a read on
   // the clearing edge still returns the pre-clear contents.
   assign cx_view = cx | hits;

`ifdef TIA_CX_FIRST_HIT_EN
   logic [7:0] col;
   logic [7:0] s1_col;
   logic [7:0] fh_col;
   logic       fh_valid;
   logic       fh_event;
   logic [7:0] fh_col_view;
   logic       fh_valid_view;

   // Column counter: counts unblanked pixels, saturates, line_start restarts it
   always_ff @(posedge clkp) begin
      if (!reset_bar) begin
         col <= 8'd0;
      end else if (line_start) begin
         col <= 8'd0;
      end else if (!blank && col != 8'hFF) begin
         col <= col + 8'd1;
      end
   end

   // Column of the pixel currently held in S1
   always_ff @(posedge clkp) begin
      if (!reset_bar) begin
         s1_col <= 8'd0;
      end else begin
         s1_col <= col;
      end
   end

   assign fh_event = hits[CX_P0P1] & ~cx[CX_P0P1];

   // First-hit record: captured only on the P0-P1 latch 0->1 transition
   always_ff @(posedge clkp) begin
      if (!reset_bar) begin
         fh_col   <= 8'hFF;
         fh_valid <= 1'b0;
      end else if (cxclr) begin
         fh_col   <= 8'hFF;
         fh_valid <= 1'b0;
      end else if (fh_event) begin
         fh_col   <= s1_col;
         fh_valid <= 1'b1;
      end
   end

   assign fh_col_view   = fh_event ? s1_col : fh_col;
   assign fh_valid_view = fh_valid | fh_event;
`else
   logic unused_line_start;
   assign unused_line_start = line_start;
`endif

   // Collision register read map
   always_comb begin
      rd_mux = 8'h00;
      case (addr)
         4'd0: rd_mux = {cx_view[CX_M0P1], cx_view[CX_M0P0], 6'b0};
         4'd1: rd_mux = {cx_view[CX_M1P0], cx_view[CX_M1P1], 6'b0};
         4'd2: rd_mux = {cx_view[CX_P0PF], cx_view[CX_P0BL], 6'b0};
         4'd3: rd_mux = {cx_view[CX_P1PF], cx_view[CX_P1BL], 6'b0};
         4'd4: rd_mux = {cx_view[CX_M0PF], cx_view[CX_M0BL], 6'b0};
         4'd5: rd_mux = {cx_view[CX_M1PF], cx_view[CX_M1BL], 6'b0};
         4'd6: rd_mux = {cx_view[CX_BLPF], 7'b0};
         4'd7: rd_mux = {cx_view[CX_P0P1], cx_view[CX_M0M1], 6'b0};
`ifdef TIA_CX_FIRST_HIT_EN
         4'd8: rd_mux = fh_col_view;
         4'd9: rd_mux = {fh_valid_view, 7'b0};
`endif
         default: rd_mux = 8'h00;
      endcase
   end

   // Read response: one-cycle latency, data forced to zero when not acking
   always_ff @(posedge clkp) begin
      if (!reset_bar) begin
         rd_ack  <= 1'b0;
         rd_data <= 8'h00;
      end else begin
         rd_ack  <= rd_req;
         rd_data <= rd_req ? rd_mux : 8'h00;
      end
   end

endmodule

// File: tb/tb_tia_collision_detector.sv
// Bench for tia_collision_detector: table of pixel patterns with expected
// register images, hand sequences for clear/read/reset corner cases, and a
// scoreboard queue of expected read responses checked on the falling edge.

module tb_tia_collision_detector;

   logic       clkp;
   logic       reset_bar;
   logic       p0, p1, m0, m1, bl, pf;
   logic       blank;
   logic       line_start;
   logic       cxclr;
   logic       rd_req;
   logic [3:0] addr;
   logic       rd_ack;
   logic [7:0] rd_data;

   tia_collision_detector dut (
      .clkp       (clkp),
      .reset_bar  (reset_bar),
      .p0         (p0),
      .p1         (p1),
      .m0         (m0),
      .m1         (m1),
      .bl         (bl),
      .pf         (pf),
      .blank      (blank),
      .line_start (line_start),
      .cxclr      (cxclr),
      .rd_req     (rd_req),
      .addr       (addr),
      .rd_ack     (rd_ack),
      .rd_data    (rd_data)
   );

   initial clkp = 1'b0;
   always #5 clkp = ~clkp;

   typedef struct {
      logic [7:0] data;
      logic [3:0] a;
      int         id;
   } rec_t;

   typedef struct {
      logic [5:0]  px;     // {p0,p1,m0,m1,bl,pf}
      logic        blk;
      logic [63:0] exp;    // byte i = expected read of addr i
   } vec_t;

   rec_t exp_q[$];
   vec_t vecs[10];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;

   // Scoreboard: every cycle either a queued read is due or the bus is idle
   always @(negedge clkp) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            rec_t r;
            r = exp_q.pop_front();
            total++;
            if (rd_ack !== 1'b1 || rd_data !== r.data) begin
               bad++;
               $display("FAIL read id=%0d addr=%0d: got ack=%b data=%h, want ack=1 data=%h",
                        r.id, r.a, rd_ack, rd_data, r.data);
            end
         end else begin
            total++;
            if (rd_ack !== 1'b0 || rd_data !== 8'h00) begin
               bad++;
               $display("FAIL idle: got ack=%b data=%h, want ack=0 data=00", rd_ack, rd_data);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   task automatic tick(input bit push, input logic [7:0] e, input int id);
      logic [3:0] a;
      a = addr;
      @(posedge clkp);
      #1;
      if (push) begin
         rec_t r;
         r.data = e;
         r.a    = a;
         r.id   = id;
         exp_q.push_back(r);
      end
   endtask

   task automatic set_px(input logic [5:0] v, input logic b);
      {p0, p1, m0, m1, bl, pf} = v;
      blank = b;
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] e, input int id);
      rd_req = 1'b1;
      addr   = a;
      tick(1'b1, e, id);
   endtask

   task automatic idle();
      set_px(6'b0, 1'b0);
      rd_req = 1'b0;
      cxclr  = 1'b0;
      tick(1'b0, 8'h00, 0);
   endtask

   task automatic clear();
      set_px(6'b0, 1'b0);
      cxclr = 1'b1;
      tick(1'b0, 8'h00, 0);
      cxclr = 1'b0;
   endtask

   initial begin
      vecs[0] = '{6'b110000, 1'b0, 64'h80_00_00_00_00_00_00_00};
      vecs[1] = '{6'b110000, 1'b1, 64'h00_00_00_00_00_00_00_00};
      vecs[2] = '{6'b111111, 1'b0, 64'hC0_80_C0_C0_C0_C0_C0_C0};
      vecs[3] = '{6'b101000, 1'b0, 64'h00_00_00_00_00_00_00_40};
      vecs[4] = '{6'b100100, 1'b0, 64'h00_00_00_00_00_00_80_00};
      vecs[5] = '{6'b000011, 1'b0, 64'h00_80_00_00_00_00_00_00};
      vecs[6] = '{6'b010010, 1'b0, 64'h00_00_00_00_40_00_00_00};
      vecs[7] = '{6'b001101, 1'b0, 64'h40_00_80_80_00_00_00_00};
      vecs[8] = '{6'b100011, 1'b0, 64'h00_80_00_00_00_C0_00_00};
      vecs[9] = '{6'b100000, 1'b0, 64'h00_00_00_00_00_00_00_00};

      reset_bar  = 1'b0;
      set_px(6'b0, 1'b0);
      line_start = 1'b0;
      cxclr      = 1'b0;
      rd_req     = 1'b0;
      addr       = 4'd0;
      tick(1'b0, 8'h00, 0);
      mon_en = 1'b1;
      tick(1'b0, 8'h00, 0);
      reset_bar = 1'b1;
      idle();

      // Reset image: all sixteen addresses, back-to-back
      for (int a = 0; a < 16; a++) begin
         logic [7:0] e;
         e = 8'h00;
`ifdef TIA_CX_FIRST_HIT_EN
         if (a == 8) e = 8'hFF;
`endif
         rd(a[3:0], e, 100 + a);
      end
      idle();

      // Table-driven pixel patterns
      for (int v = 0; v < 10; v++) begin
         clear();
         set_px(vecs[v].px, vecs[v].blk);
         tick(1'b0, 8'h00, 0);
         idle();
         for (int a = 0; a < 8; a++) begin
            logic [63:0] ex;
            ex = vecs[v].exp;
            rd(a[3:0], ex[8*a +: 8], 200 + 10 * v + a);
         end
         idle();
      end

      // Clear one edge after the collision: read on that edge sees it, later read doesn't
      clear();
      set_px(6'b110000, 1'b0);
      tick(1'b0, 8'h00, 0);
      set_px(6'b0, 1'b0);
      cxclr = 1'b1;
      rd(4'd7, 8'h80, 300);
      cxclr = 1'b0;
      rd(4'd7, 8'h00, 301);
      idle();

      // Held read stepping addresses while m1/pf collide
      clear();
      set_px(6'b000101, 1'b0);
      rd(4'd0, 8'h00, 310);
      set_px(6'b0, 1'b0);
      rd(4'd1, 8'h00, 311);
      rd(4'd2, 8'h00, 312);
      rd(4'd5, 8'h80, 313);
      idle();

      // Sticky: further collisions and idle pixels leave the latch unchanged
      set_px(6'b000101, 1'b0);
      tick(1'b0, 8'h00, 0);
      idle();
      idle();
      rd(4'd5, 8'h80, 320);
      idle();

`ifdef TIA_CX_FIRST_HIT_EN
      // First-hit column capture
      clear();
      line_start = 1'b1;
      tick(1'b0, 8'h00, 0);
      line_start = 1'b0;
      for (int i = 0; i < 40; i++) tick(1'b0, 8'h00, 0);
      set_px(6'b110000, 1'b0);
      tick(1'b0, 8'h00, 0);
      set_px(6'b0, 1'b0);
      rd(4'd8, 8'd40, 400);
      rd(4'd9, 8'h80, 401);
      idle();
      set_px(6'b110000, 1'b0);
      tick(1'b0, 8'h00, 0);
      idle();
      rd(4'd8, 8'd40, 402);
      rd(4'd9, 8'h80, 403);
      idle();
      clear();
      rd(4'd8, 8'hFF, 404);
      rd(4'd9, 8'h00, 405);
      idle();
`endif

      // Reset in the middle of a read: no ack follows, latches are gone
      set_px(6'b110000, 1'b0);
      tick(1'b0, 8'h00, 0);
      set_px(6'b0, 1'b0);
      rd_req    = 1'b1;
      addr      = 4'd7;
      reset_bar = 1'b0;
      tick(1'b0, 8'h00, 0);
      reset_bar = 1'b1;
      rd(4'd7, 8'h00, 500);
      idle();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
